// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if: request/grant bundle between the requesters and the arbiter
interface rr_arbiter8_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;
  modport master (output req, input gnt, input gnt_idx, input gnt_vld, input timeout);
  modport slave  (input req, output gnt, output gnt_idx, output gnt_vld, output timeout);
endinterface

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with registered one-hot grant
// Defining ARB_TIMEOUT_EN adds the HOLD_MAX hold limit, PARK state and timeout pulse
module rr_arbiter8 #(
  parameter int HOLD_MAX = 16
) (
  input logic          sys_clk,
  input logic          sys_rst_n,
  rr_arbiter8_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT, PARK} state_t;
  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d, idx_q, idx_d, win, nxt;
  logic [7:0] gnt_q, gnt_d;
  logic       vld_q, vld_d;
  function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
    pick = p;
    for (int k = 7; k >= 0; k--)
      if (r[p + 3'(k)]) pick = p + 3'(k);
  endfunction
  assign win = pick(bus.req, ptr_q);
  assign nxt = pick(bus.req, idx_q + 3'd1);
`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic       to_q, to_d;
`else
  logic unused_hold;
  assign unused_hold = HOLD_MAX != 0;
`endif
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
`ifdef ARB_TIMEOUT_EN
    hold_d  = hold_q;
    to_d    = 1'b0;
`endif
    case (state_q)
      GRANT:
        if (!bus.req[idx_q]) begin
          ptr_d   = idx_q + 3'd1;
          state_d = |bus.req ? GRANT : IDLE;
          idx_d   = |bus.req ? nxt : 3'd0;
`ifdef ARB_TIMEOUT_EN
          hold_d  = 8'd0;
        end else if (hold_q == 8'(HOLD_MAX - 1)) begin
          state_d = PARK;
          ptr_d   = idx_q + 3'd1;
          idx_d   = 3'd0;
          to_d    = 1'b1;
        end else begin
          hold_d  = hold_q + 8'd1;
`endif
        end
      default: begin
        state_d = |bus.req ? GRANT : IDLE;
        idx_d   = |bus.req ? win : 3'd0;
`ifdef ARB_TIMEOUT_EN
        hold_d  = 8'd0;
`endif
      end
    endcase
    vld_d = state_d == GRANT;
    gnt_d = vld_d ? 8'd1 << idx_d : 8'd0;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      idx_q   <= 3'd0;
      gnt_q   <= 8'd0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
    end
`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      hold_q <= 8'd0;
      to_q   <= 1'b0;
    end else begin
      hold_q <= hold_d;
      to_q   <= to_d;
    end
  assign bus.timeout = to_q;
`else
  assign bus.timeout = 1'b0;
`endif
  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = idx_q;
  assign bus.gnt_vld = vld_q;
endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter: HOLD_MAX, default 16, max consecutive grant cycles per requester (legal 2..255).
REQ-002 sys_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 sys_rst_n  input  1  reset; asynchronous, active-low.
REQ-004 req  input  8  request lines; bit i = requester i; level-sensitive, held high while resource wanted.
REQ-005 gnt  output  8  one-hot grant, registered; all-zero when no grant.
REQ-006 gnt_idx  output  3  binary index of current grant (drives 3-to-8 decoder select); 0 when gnt_vld low.
REQ-007 gnt_vld  output  1  high while a grant is active.
REQ-008 timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-009 States SHALL be IDLE, GRANT, PARK; gnt_vld SHALL be high only in GRANT.
REQ-010 gnt SHALL always equal the 3-to-8 decode of gnt_idx when gnt_vld is high, else 8'h00.
REQ-011 Arbitration: winner = first set bit of req searched from index ptr upward, wrapping 7->0; ptr is 3-bit, reset 0.
REQ-012 IDLE: if req != 0 at edge N, GRANT with winner SHALL be visible after edge N (1-cycle latency); else stay IDLE.
REQ-013 GRANT: while req[gnt_idx] sampled high and hold limit not reached, grant SHALL stay unchanged.
REQ-014 Release: when req[gnt_idx] sampled low, ptr <= gnt_idx+1 (mod 8); if other req bits set in same cycle, next grant SHALL follow with no gap cycle, else IDLE.
REQ-015 Released requester SHALL NOT be re-granted on the handoff cycle unless it is the only requester re-asserting after the gap rules of REQ-014.
REQ-016 hold_cnt (8-bit) SHALL clear on every new grant and increment each GRANT cycle; saturation never occurs since HOLD_MAX <= 255.
REQ-017 Timeout: grant active HOLD_MAX cycles with req still high -> PARK for exactly one cycle (gnt=0, gnt_vld=0), timeout=1 during that cycle, ptr <= gnt_idx+1.
REQ-018 PARK always exits after one cycle: arbitrate per REQ-011 (GRANT) or IDLE if req==0.
REQ-019 Requests arriving/dropping on non-granted bits SHALL never disturb an active grant.
REQ-020 All outputs SHALL be registered; no combinational path req->gnt.

Reset
REQ-021 sys_rst_n low SHALL immediately force IDLE, ptr=0, hold_cnt=0, gnt=8'h00, gnt_idx=0, gnt_vld=0, timeout=0, regardless of clock.
REQ-022 Reset asserted mid-grant SHALL drop grant without PARK or timeout pulse; after release first arbitration starts from ptr=0.

Configuration
REQ-023 Macro ARB_TIMEOUT_EN defined: hold limit, PARK state and timeout output behave per REQ-016..REQ-018.
REQ-024 ARB_TIMEOUT_EN undefined: no hold counter or PARK; grant held until requester releases; timeout tied 0; HOLD_MAX ignored.

Verification
REQ-025 Reset then req=8'h24 -> one cycle later gnt=8'h04, gnt_idx=2, gnt_vld=1.
REQ-026 req=8'hFF, each winner drops req one cycle after grant then reasserts -> grant order 0,1,...,7,0 with no gap cycles.
REQ-027 ptr=7 state (grant 6 released), req=8'h41 -> next gnt=8'h01 (wrap check), not 8'h40.
REQ-028 ARB_TIMEOUT_EN, HOLD_MAX=4, req=8'h09 held -> gnt=8'h01 for 4 cycles, 1 PARK cycle with timeout=1, then gnt=8'h08.
REQ-029 Without ARB_TIMEOUT_EN, req=8'h03 held 300 cycles -> gnt=8'h01 throughout, timeout never 1.
REQ-030 sys_rst_n pulsed low between clock edges during grant to idx 5 -> outputs zero immediately, next grant from ptr=0.
